// File: rtl/window2x2_gen_if.sv
// Handshake bundle between a raster pixel source, the 2x2 window generator and a downstream MAC.
// The slave modport is the window generator's view. The master modport is the environment's view.
interface window2x2_gen_if #(
    parameter int WIDTH = 8
);
    logic               pix_valid;
    logic [WIDTH-1:0]   pix_data;
    logic               pix_ready;
    logic               win_valid;
    logic [4*WIDTH-1:0] win_data;
    logic               win_last;
    logic               win_ready;

    modport slave (
        input  pix_valid, pix_data, win_ready,
        output pix_ready, win_valid, win_data, win_last
    );

    modport master (
        output pix_valid, pix_data, win_ready,
        input  pix_ready, win_valid, win_data, win_last
    );
endinterface

// File: rtl/window2x2_gen.sv
// Builds stride-1 2x2 windows from a raster pixel stream using one line buffer.
// Each window is registered with one cycle of latency, and frames can follow each other back-to-back.
module window2x2_gen #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             clk,
    input  logic             rst,
    window2x2_gen_if.slave   bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [WIDTH-1:0]   top_prev_q, top_prev_d;
    logic [WIDTH-1:0]   cur_prev_q, cur_prev_d;
    logic               win_valid_q, win_valid_d;
    logic               win_last_q, win_last_d;
    logic [4*WIDTH-1:0] win_data_q, win_data_d;

    logic [WIDTH-1:0]   linebuf_q [IMG_W];
    logic [WIDTH-1:0]   top;
    logic               accept;
    logic               form;
    logic               col_wrap;
    logic               frame_end;

    assign bus.pix_ready = !win_valid_q || bus.win_ready;
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign top           = linebuf_q[col_q];
    assign col_wrap      = (col_q == COL_LAST);
    assign frame_end     = col_wrap && (row_q == ROW_LAST);
    // Row 0 (FILL) and column 0 only prime the buffers.
    assign form          = accept && (state_q == RUN) && (col_q != '0);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        top_prev_d  = top_prev_q;
        cur_prev_d  = cur_prev_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        win_data_d  = win_data_q;

        if (accept) begin
            top_prev_d = top;
            cur_prev_d = bus.pix_data;
            if (col_wrap) begin
                col_d = '0;
                row_d = frame_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (frame_end) begin
                state_d = FILL;
            end else if (col_wrap && (state_q == FILL)) begin
                state_d = RUN;
            end
        end

        if (form) begin
            win_valid_d = 1'b1;
            win_last_d  = frame_end;
            win_data_d  = {bus.pix_data, cur_prev_q, top, top_prev_q};
        end else if (bus.win_ready) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= FILL;
            col_q       <= '0;
            row_q       <= '0;
            top_prev_q  <= '0;
            cur_prev_q  <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            top_prev_q  <= top_prev_d;
            cur_prev_q  <= cur_prev_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_data_q  <= win_data_d;
        end
    end

    // NOTE: the line buffer has no reset. Row 0 of every frame rewrites each entry before any window reads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf_q[col_q] <= bus.pix_data;
        end
    end

    assign bus.win_valid = win_valid_q;
    assign bus.win_last  = win_last_q;
    assign bus.win_data  = win_data_q;
endmodule

// File: tb/tb_window2x2_gen.sv
// Bench for window2x2_gen: directed 4x3 streams (stall, mid-frame reset, back-to-back frames)
// and randomized 8x8 traffic checked against a frame-array reference model.
module tb_window2x2_gen;
    localparam int SW = 4;
    localparam int SH = 3;
    localparam int LW = 8;
    localparam int LH = 8;
    localparam int NFRAMES = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    window2x2_gen_if #(.WIDTH(8)) s_if ();
    window2x2_gen_if #(.WIDTH(8)) l_if ();

    window2x2_gen #(.WIDTH(8), .IMG_W(SW), .IMG_H(SH)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    window2x2_gen #(.WIDTH(8), .IMG_W(LW), .IMG_H(LH)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (l_if.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Small-image model. Pixel k (1-based, counted across frames) has value k.
    function automatic bit small_has_win(input int k);
        int idx = (k - 1) % (SW * SH);
        return ((idx / SW) >= 1) && ((idx % SW) >= 1);
    endfunction

    function automatic logic [31:0] small_win(input int k);
        int base = ((k - 1) / (SW * SH)) * (SW * SH) + 1;
        int idx  = (k - 1) % (SW * SH);
        int r    = idx / SW;
        int c    = idx % SW;
        int tl   = base + (r - 1) * SW + (c - 1);
        return {8'(tl + SW + 1), 8'(tl + SW), 8'(tl + 1), 8'(tl)};
    endfunction

    function automatic bit small_last(input int k);
        return ((k - 1) % (SW * SH)) == (SW * SH - 1);
    endfunction

    // Streams pixels 1..n with win_ready=1 and checks the window that follows each accept one cycle later.
    task automatic stream_small(input int n);
        int wins = 0;
        bit exp_v;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            s_if.pix_valid = (k <= n);
            s_if.pix_data  = 8'(k);
            s_if.win_ready = 1'b1;
            #1;
            if (k <= n) check("s_pix_ready", 64'(s_if.pix_ready), 64'd1);
            if (k > 1) begin
                exp_v = small_has_win(k - 1);
                check("s_win_valid", 64'(s_if.win_valid), 64'(exp_v));
                if (exp_v && s_if.win_valid) begin
                    wins++;
                    check("s_win_data", 64'(s_if.win_data), 64'(small_win(k - 1)));
                    check("s_win_last", 64'(s_if.win_last), 64'(small_last(k - 1)));
                end
            end
        end
        s_if.pix_valid = 1'b0;
        check("s_win_count", 64'(wins), 64'((n / (SW * SH)) * (SW - 1) * (SH - 1)));
    endtask

    // Large-image random test state
    logic [7:0]  pix_mem [NFRAMES * LW * LH];
    logic [32:0] exp_q [$];

    task automatic random_large();
        int pi = 0;
        int got_wins = 0;
        int got_lasts = 0;
        int cycles = 0;
        bit prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic [32:0] e;
        for (int f = 0; f < NFRAMES; f++)
            for (int r = 0; r < LH; r++)
                for (int c = 0; c < LW; c++)
                    pix_mem[(f * LH + r) * LW + c] = 8'($urandom_range(0, 255));
        for (int f = 0; f < NFRAMES; f++)
            for (int r = 1; r < LH; r++)
                for (int c = 1; c < LW; c++) begin
                    int b = f * LH * LW;
                    exp_q.push_back({(r == LH - 1) && (c == LW - 1),
                                     pix_mem[b + r * LW + c], pix_mem[b + r * LW + c - 1],
                                     pix_mem[b + (r - 1) * LW + c], pix_mem[b + (r - 1) * LW + c - 1]});
                end
        while ((pi < NFRAMES * LW * LH || exp_q.size() != 0) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            l_if.pix_valid = (pi < NFRAMES * LW * LH) && ($urandom_range(0, 3) != 0);
            l_if.pix_data  = (pi < NFRAMES * LW * LH) ? pix_mem[pi] : 8'h00;
            l_if.win_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                check("l_hold_valid", 64'(l_if.win_valid), 64'd1);
                check("l_hold_data", 64'(l_if.win_data), 64'(prev_data));
                check("l_hold_last", 64'(l_if.win_last), 64'(prev_last));
            end
            if (l_if.win_valid && !l_if.win_ready)
                check("l_pix_ready_stall", 64'(l_if.pix_ready), 64'd0);
            if (l_if.pix_valid && l_if.pix_ready) pi++;
            if (l_if.win_valid && l_if.win_ready) begin
                got_wins++;
                if (l_if.win_last) got_lasts++;
                if (exp_q.size() == 0) begin
                    check("l_extra_window", 64'(got_wins), 64'(NFRAMES * (LW - 1) * (LH - 1)));
                end else begin
                    e = exp_q.pop_front();
                    check("l_win_data", 64'(l_if.win_data), 64'(e[31:0]));
                    check("l_win_last", 64'(l_if.win_last), 64'(e[32]));
                end
            end
            prev_stall = l_if.win_valid && !l_if.win_ready;
            prev_data  = l_if.win_data;
            prev_last  = l_if.win_last;
        end
        l_if.pix_valid = 1'b0;
        l_if.win_ready = 1'b1;
        check("l_timeout", 64'(cycles < 20000), 64'd1);
        check("l_win_count", 64'(got_wins), 64'(NFRAMES * (LW - 1) * (LH - 1)));
        check("l_last_count", 64'(got_lasts), 64'(NFRAMES));
    endtask

    initial begin
        s_if.pix_valid = 1'b0; s_if.pix_data = '0; s_if.win_ready = 1'b1;
        l_if.pix_valid = 1'b0; l_if.pix_data = '0; l_if.win_ready = 1'b1;
        #1;
        check("rst_win_valid", 64'(s_if.win_valid), 64'd0);
        check("rst_win_data", 64'(s_if.win_data), 64'd0);
        check("rst_win_last", 64'(s_if.win_last), 64'd0);
        check("rst_pix_ready", 64'(s_if.pix_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Backpressure on the first window, then a reset mid-frame after pixel 7
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            s_if.pix_valid = 1'b1; s_if.pix_data = 8'(k); s_if.win_ready = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_if.pix_valid = 1'b1; s_if.pix_data = 8'd7; s_if.win_ready = 1'b0;
            #1;
            check("stall_pix_ready", 64'(s_if.pix_ready), 64'd0);
            check("stall_win_valid", 64'(s_if.win_valid), 64'd1);
            check("stall_win_data", 64'(s_if.win_data), 64'h06050201);
        end
        @(negedge clk);
        s_if.win_ready = 1'b1;
        #1;
        check("resume_pix_ready", 64'(s_if.pix_ready), 64'd1);
        check("resume_win_data", 64'(s_if.win_data), 64'h06050201);
        @(negedge clk);
        s_if.pix_valid = 1'b0;
        #1;
        check("resume_next_valid", 64'(s_if.win_valid), 64'd1);
        check("resume_next_data", 64'(s_if.win_data), 64'h07060302);
        rst = 1'b1;
        #1;
        check("midrst_win_valid", 64'(s_if.win_valid), 64'd0);
        check("midrst_win_data", 64'(s_if.win_data), 64'd0);
        check("midrst_win_last", 64'(s_if.win_last), 64'd0);
        check("midrst_pix_ready", 64'(s_if.pix_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Two back-to-back frames 1..12 and 13..24 after the mid-frame reset
        stream_small(2 * SW * SH);

        random_large();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/window2x2_gen.md
WINDOW2X2_GEN -- requirements
Module: window2x2_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 8, giving the image width in pixels (minimum 2).
REQ-003 SHALL have parameter IMG_H, default 8, giving the image height in rows (minimum 2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pix_valid  input  1  upstream pixel present.
REQ-007 SHALL have port pix_data  input  WIDTH  pixel value; pixels arrive in raster order, row-major.
REQ-008 SHALL have port pix_ready  output  1  block accepts a pixel this cycle.
REQ-009 SHALL have port win_valid  output  1  window present on win_data.
REQ-010 SHALL have port win_data  output  4*WIDTH  2x2 window: [WIDTH-1:0] top-left, [2W-1:W] top-right, [3W-1:2W] bottom-left, [4W-1:3W] bottom-right (mac2 operand order).
REQ-011 SHALL have port win_last  output  1  marks the final window of a frame.
REQ-012 SHALL have port win_ready  input  1  downstream MAC accepts the window.

Function
REQ-013 SHALL accept a pixel when pix_valid && pix_ready; pix_ready SHALL equal !win_valid || win_ready (combinational).
REQ-014 SHALL transfer a window when win_valid && win_ready.
REQ-015 SHALL track col (0..IMG_W-1) and row (0..IMG_H-1) of the next pixel; each accept increments col, wraps col to 0 with row+1, and after (IMG_W-1, IMG_H-1) wraps both to 0.
REQ-016 SHALL use FSM states FILL (row 0, no windows emitted) and RUN (row >= 1); FILL->RUN on accepting pixel (IMG_W-1, 0); RUN->FILL on accepting the last pixel of the frame.
REQ-017 SHALL hold a one-row line buffer of IMG_W pixels, a register top_prev (line-buffer entry of the previous column) and a register cur_prev (previous accepted pixel).
REQ-018 On accept at column c, SHALL read top = linebuf[c], write linebuf[c] <= pix_data, top_prev <= top, cur_prev <= pix_data.
REQ-019 On accept at row >= 1 and col >= 1, SHALL register win_data = {pix_data, cur_prev, top, top_prev} (BR, BL, TR, TL from MSB down) and set win_valid the next cycle (latency 1).
REQ-020 Accepts at col == 0 or row == 0 SHALL update buffers only and produce no window.
REQ-021 SHALL emit exactly (IMG_W-1)*(IMG_H-1) windows per frame, stride 1, no padding.
REQ-022 SHALL set win_last with the window formed from pixel (IMG_W-1, IMG_H-1) only.
REQ-023 While win_valid && !win_ready, win_data and win_last SHALL stay stable and no pixel SHALL be accepted.
REQ-024 When a window transfers and no new window is formed in that cycle, win_valid SHALL clear; a simultaneous transfer and new-window formation SHALL keep win_valid high with new data (back-to-back, one window per cycle).
REQ-025 Frames SHALL stream back-to-back with no idle cycle required between them.

Reset
REQ-026 On rst high, SHALL immediately clear win_valid, win_last, win_data, col, row, top_prev, cur_prev and set state FILL; pix_ready is therefore 1.
REQ-027 Line buffer contents SHALL NOT require reset; no window SHALL use pre-reset data because row 0 refills it.
REQ-028 Reset mid-frame SHALL discard the partial frame; the next accepted pixel is (0,0).

Verification
REQ-029 IMG_W=4, IMG_H=3, WIDTH=8, win_ready=1, pixels 1..12 streamed every cycle -> 6 windows; first is {TL=1,TR=2,BL=5,BR=6} one cycle after accepting pixel 6; last is {7,8,11,12} with win_last=1.
REQ-030 Same stream -> no window after accepting pixels 1-5 or pixel 9 (col 0); windows after 6,7,8,10,11,12 only.
REQ-031 win_ready held 0 for 3 cycles after first window -> pix_ready=0, win_data stays 0x06050201, then transfer resumes with {2,3,6,7}.
REQ-032 Second frame 13..24 immediately after first -> first window {13,14,17,18}, no data from frame 1.
REQ-033 rst asserted after pixel 7 of a frame, then pixels 1..12 -> outputs 0 during reset, then identical window sequence to REQ-029.
REQ-034 Random pix_valid/win_ready gaps over 10 frames with IMG_W=8, IMG_H=8 -> 49 windows per frame matching a reference model, one win_last per frame.
